rdma_sq_arbiter: RTL and testbench
==================================

RDMA_SQ_ARBITER -- requirements
Module: rdma_sq_arbiter

Interface
REQ-001 Parameter N_REQ SHALL default to 4 and set the number of requester send-queue ports, range 2..16.
REQ-002 Parameter MAX_OUT SHALL default to 8 and set the maximum outstanding (unacknowledged) commands per requester, range 1..255.
REQ-003 Parameter REQ_BITS SHALL default to RDMA_REQ_BITS and set the width of the opaque SQ command word.
REQ-004 nclk SHALL be an input of 1 bit: the single clock for all logic.
REQ-005 nreset SHALL be an input of 1 bit: reset, asynchronous and active-high.
REQ-006 s_sq_valid SHALL be an input of N_REQ bits: per-requester command valid.
REQ-007 s_sq_ready SHALL be an output of N_REQ bits: per-requester command accept.
REQ-008 s_sq_data SHALL be an input of N_REQ*REQ_BITS bits: per-requester command; requester i occupies slice [i*REQ_BITS +: REQ_BITS].
REQ-009 m_sq_valid, m_sq_ready and m_sq_data SHALL be an output of 1 bit, an input of 1 bit and an output of REQ_BITS bits: the arbitrated command toward the RoCE stack SQ.
REQ-010 m_sq_id SHALL be an output of clog2(N_REQ) bits: the source index of m_sq_data.
REQ-011 s_ack_valid and s_ack_id SHALL be inputs of 1 bit and clog2(N_REQ) bits: each valid cycle releases one credit for requester s_ack_id; no ready is returned, and the block always accepts.
REQ-012 err_underflow SHALL be an output of 1 bit: a sticky credit-underflow flag.
REQ-013 busy SHALL be an output of N_REQ bits: bit i is 1 when requester i has a nonzero outstanding count.

Function
REQ-014 The block SHALL have states EMPTY (output register invalid) and FULL (output register valid).
- EMPTY->FULL on a grant.
- FULL->EMPTY on m_sq_ready with no new grant.
- FULL->FULL on m_sq_ready with a new grant.
- FULL holds while m_sq_ready=0.
REQ-015 A grant SHALL be possible only when the state is EMPTY, or FULL with m_sq_ready=1 in that cycle.
REQ-016 Requester i SHALL be eligible when s_sq_valid[i]=1 and outstanding[i] < MAX_OUT.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo N_REQ, and the first eligible requester wins.
REQ-018 s_sq_ready SHALL be one-hot or zero, combinationally asserted only for the winner in a grant cycle.
REQ-019 Latency from s_sq_valid&s_sq_ready to m_sq_valid SHALL be exactly 1 cycle.
REQ-020 Sustained throughput SHALL be one command per cycle while m_sq_ready=1 and any requester is eligible.
REQ-021 m_sq_data and m_sq_id SHALL be stable while m_sq_valid=1 and m_sq_ready=0.
REQ-022 outstanding[i] SHALL increment on a grant to i and decrement on a s_ack_valid with s_ack_id=i.
REQ-023 A grant and an ack to the same i in the same cycle SHALL leave outstanding[i] unchanged.
REQ-024 A requester at outstanding = MAX_OUT SHALL be skipped; others are not blocked.
REQ-025 An ack to a requester with outstanding = 0 SHALL leave the count at 0 and set err_underflow, which remains set until reset.
REQ-026 An ack with s_ack_id >= N_REQ SHALL be ignored and SHALL set err_underflow.
REQ-027 outstanding counters SHALL be clog2(MAX_OUT+1) bits wide and SHALL never wrap.
REQ-028 last_grant SHALL update only on a grant.

Reset
REQ-029 nreset SHALL asynchronously force:
- state EMPTY, m_sq_valid=0, m_sq_data=0, m_sq_id=0;
- all outstanding=0, last_grant=N_REQ-1 (so requester 0 has first priority);
- err_underflow=0, busy=0, any statistics counters=0.
REQ-030 s_sq_ready SHALL be 0 while nreset=1.
REQ-031 A command held in the output register at reset assertion SHALL be discarded, and its credit SHALL not be restored.

Configuration
REQ-032 With macro RDMA_SQ_ARB_STATS_EN defined, the block SHALL add output stat_grants of N_REQ*32 bits: per-requester grant counters that increment on each grant and wrap at 2^32.
REQ-033 With RDMA_SQ_ARB_STATS_EN defined, the block SHALL add output stat_stall of 32 bits: counts cycles where m_sq_valid=1 and m_sq_ready=0, and wraps.
REQ-034 Without RDMA_SQ_ARB_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Round-robin: N_REQ=4, all valid, m_sq_ready=1, MAX_OUT=8, no acks -> m_sq_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, with the first m_sq_valid one cycle after reset release plus the first valid.
REQ-036 Credit limit: only requester 2 valid, MAX_OUT=2, no acks -> two grants, then s_sq_ready[2]=0 indefinitely; one ack id=2 -> exactly one further grant one cycle later.
REQ-037 Backpressure: m_sq_ready=0 for 5 cycles with m_sq_valid=1 -> m_sq_data/m_sq_id unchanged, s_sq_ready=0 throughout; with stats enabled, stat_stall=5.
REQ-038 Simultaneous events: grant to 1 and ack id=1 in the same cycle at outstanding[1]=3 -> outstanding[1]=3, busy[1]=1.
REQ-039 Underflow: ack id=0 with outstanding[0]=0 -> err_underflow=1 next cycle, outstanding[0]=0; it stays 1 until nreset pulses.
REQ-040 Reset mid-operation: assert nreset while FULL with outstanding[3]=5 -> m_sq_valid=0 and busy=0 immediately (asynchronous); after release, the first grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/rdma_sq_arbiter.sv
// Round-robin RDMA send-queue arbiter with per-requester credit tracking.
// Define RDMA_SQ_ARB_STATS_EN to add grant/stall statistics counters.
package rdma_sq_pkg;
  localparam int RDMA_REQ_BITS = 64;
endpackage

module rdma_sq_arbiter
  import rdma_sq_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_OUT  = 8,
  parameter int REQ_BITS = RDMA_REQ_BITS
) (
  input  logic                      nclk,
  input  logic                      nreset,
  input  logic [N_REQ-1:0]          s_sq_valid,
  output logic [N_REQ-1:0]          s_sq_ready,
  input  logic [N_REQ*REQ_BITS-1:0] s_sq_data,
  output logic                      m_sq_valid,
  input  logic                      m_sq_ready,
  output logic [REQ_BITS-1:0]       m_sq_data,
  output logic [$clog2(N_REQ)-1:0]  m_sq_id,
  input  logic                      s_ack_valid,
  input  logic [$clog2(N_REQ)-1:0]  s_ack_id,
  output logic                      err_underflow,
`ifdef RDMA_SQ_ARB_STATS_EN
  output logic [N_REQ*32-1:0]       stat_grants,
  output logic [31:0]               stat_stall,
`endif
  output logic [N_REQ-1:0]          busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   outstanding [N_REQ];
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] inc;
  logic [N_REQ-1:0] dec;
  logic [N_REQ-1:0] zero;
  logic            found;
  logic            grant;
  logic            can_load;
  logic            ack_ok;

  assign m_sq_valid = (state == FULL);
  assign can_load   = (state == EMPTY) || m_sq_ready;
  assign ack_ok     = s_ack_valid && (32'(s_ack_id) < N_REQ);

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = s_sq_valid[i] && (outstanding[i] < CW'(MAX_OUT));
      zero[i] = (outstanding[i] == '0);
      busy[i] = !zero[i];
    end
  end

  // First eligible requester after the previous winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((32'(last_grant) + k) % N_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant      = found && can_load && !nreset;
    s_sq_ready = grant ? (N_REQ'(1) << win) : '0;
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      inc[i] = grant && (win == IW'(i));
      dec[i] = ack_ok && (s_ack_id == IW'(i));
    end
  end

  always_ff @(posedge nclk or posedge nreset) begin
    if (nreset) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (grant) state_nx = FULL;
      FULL:  if (m_sq_ready && !grant) state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge nclk or posedge nreset) begin
    if (nreset) begin
      m_sq_data  <= '0;
      m_sq_id    <= '0;
      last_grant <= IW'(N_REQ - 1);
    end else if (grant) begin
      m_sq_data  <= s_sq_data[win*REQ_BITS +: REQ_BITS];
      m_sq_id    <= win;
      last_grant <= win;
    end
  end

  // A grant and an ack to the same requester cancel out.
  always_ff @(posedge nclk or posedge nreset) begin
    if (nreset) begin
      for (int i = 0; i < N_REQ; i++) outstanding[i] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (inc[i] && !dec[i])
          outstanding[i] <= outstanding[i] + CW'(1);
        else if (dec[i] && !inc[i] && !zero[i])
          outstanding[i] <= outstanding[i] - CW'(1);
      end
      if ((s_ack_valid && !ack_ok) || |(dec & ~inc & zero))
        err_underflow <= 1'b1;
    end
  end

`ifdef RDMA_SQ_ARB_STATS_EN
  always_ff @(posedge nclk or posedge nreset) begin
    if (nreset) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant)
        stat_grants[win*32 +: 32] <= stat_grants[win*32 +: 32] + 32'd1;
      if (m_sq_valid && !m_sq_ready)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rdma_sq_arbiter.sv
// Testbench for rdma_sq_arbiter: directed vectors plus a randomized model check.
// Stats checks are compiled in when RDMA_SQ_ARB_STATS_EN is defined.
module tb_rdma_sq_arbiter;
  import rdma_sq_pkg::*;

  localparam int N  = 4;
  localparam int RB = RDMA_REQ_BITS;
  localparam int MO = 8;

  logic          nclk = 1'b0;
  logic          nreset = 1'b1;
  logic [N-1:0]  s_sq_valid, s_sq_ready;
  logic [N*RB-1:0] s_sq_data;
  logic          m_sq_valid, m_sq_ready;
  logic [RB-1:0] m_sq_data;
  logic [1:0]    m_sq_id;
  logic          s_ack_valid;
  logic [1:0]    s_ack_id;
  logic          err_underflow;
  logic [N-1:0]  busy;

  logic [N-1:0]  l_valid, l_ready;
  logic [N*RB-1:0] l_data;
  logic          l_mvalid, l_mready;
  logic [RB-1:0] l_mdata;
  logic [1:0]    l_mid;
  logic          l_ack_valid;
  logic [1:0]    l_ack_id;
  logic          l_err;
  logic [N-1:0]  l_busy;

`ifdef RDMA_SQ_ARB_STATS_EN
  logic [N*32-1:0] stat_grants, l_stat_grants;
  logic [31:0]     stat_stall, l_stat_stall;
`endif

  rdma_sq_arbiter #(.N_REQ(N), .MAX_OUT(MO)) dut (
    .nclk(nclk), .nreset(nreset),
    .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready),
    .m_sq_data(m_sq_data), .m_sq_id(m_sq_id),
    .s_ack_valid(s_ack_valid), .s_ack_id(s_ack_id),
    .err_underflow(err_underflow),
`ifdef RDMA_SQ_ARB_STATS_EN
    .stat_grants(stat_grants), .stat_stall(stat_stall),
`endif
    .busy(busy)
  );

  rdma_sq_arbiter #(.N_REQ(N), .MAX_OUT(2)) u_lim (
    .nclk(nclk), .nreset(nreset),
    .s_sq_valid(l_valid), .s_sq_ready(l_ready), .s_sq_data(l_data),
    .m_sq_valid(l_mvalid), .m_sq_ready(l_mready),
    .m_sq_data(l_mdata), .m_sq_id(l_mid),
    .s_ack_valid(l_ack_valid), .s_ack_id(l_ack_id),
    .err_underflow(l_err),
`ifdef RDMA_SQ_ARB_STATS_EN
    .stat_grants(l_stat_grants), .stat_stall(l_stat_stall),
`endif
    .busy(l_busy)
  );

  always #5 nclk = ~nclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic tick;
    @(posedge nclk);
    #1;
  endtask

  task automatic idle;
    s_sq_valid  = '0;
    m_sq_ready  = 1'b1;
    s_ack_valid = 1'b0;
    s_ack_id    = '0;
    l_valid     = '0;
    l_mready    = 1'b1;
    l_ack_valid = 1'b0;
    l_ack_id    = '0;
    for (int i = 0; i < N; i++) begin
      s_sq_data[i*RB +: RB] = dat(i);
      l_data[i*RB +: RB]    = dat(i);
    end
  endtask

  task automatic do_reset;
    idle();
    nreset = 1'b1;
    repeat (2) @(posedge nclk);
    #1;
    nreset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [3:0] vld;
    logic       mrdy;
    logic [3:0] e_rdy;
    logic       e_mv;
    logic [1:0] e_id;
    logic [3:0] e_busy;
  } vec_t;

  vec_t tbl [15];

  int          mout [N];
  int          mlast, mi, win, aid, sel, j;
  bit          mv, merr;
  logic [63:0] md;
  logic [3:0]  exp_rdy, exp_busy;
  int unsigned mgr [N];
  int unsigned mstall;

  initial begin
    tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 4'h0};
    tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 4'h1};
    tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 4'h3};
    tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 4'h7};
    tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 4'hF};
    tbl[5]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 4'hF};
    tbl[6]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 4'hF};
    tbl[7]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 4'hF};
    for (int r = 8; r <= 12; r++)
      tbl[r] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 4'hF};
    tbl[13] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 4'hF};
    tbl[14] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'hF};

    idle();
    s_sq_valid = 4'hF;
    #2;
    chk("rst_ready", 64'(s_sq_ready), 64'h0);
    chk("rst_mvalid", 64'(m_sq_valid), 64'h0);
    chk("rst_mdata", m_sq_data, 64'h0);
    chk("rst_mid", 64'(m_sq_id), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err_underflow), 64'h0);

    // Round robin then five cycles of backpressure
    do_reset();
    for (int r = 0; r < 15; r++) begin
      s_sq_valid = tbl[r].vld;
      m_sq_ready = tbl[r].mrdy;
      #1;
      chk($sformatf("tbl%0d_ready", r), 64'(s_sq_ready), 64'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_mvalid", r), 64'(m_sq_valid), 64'(tbl[r].e_mv));
      if (tbl[r].e_mv) begin
        chk($sformatf("tbl%0d_mid", r), 64'(m_sq_id), 64'(tbl[r].e_id));
        chk($sformatf("tbl%0d_mdata", r), m_sq_data, dat(int'(tbl[r].e_id)));
      end
      chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
      tick();
    end
`ifdef RDMA_SQ_ARB_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'd5);
    for (int i = 0; i < N; i++)
      chk($sformatf("stat_grants%0d", i), 64'(stat_grants[i*32 +: 32]), 64'd2);
`endif

    // Grant and ack to requester 1 in the same cycle at count 3
    s_sq_valid = 4'b0010;
    #1;
    chk("sim_ready_a", 64'(s_sq_ready), 64'h2);
    tick();
    s_ack_valid = 1'b1;
    s_ack_id    = 2'd1;
    #1;
    chk("sim_ready_b", 64'(s_sq_ready), 64'h2);
    tick();
    s_ack_valid = 1'b0;
    s_sq_valid  = '0;
    #1;
    chk("sim_out1", 64'(dut.outstanding[1]), 64'd3);
    chk("sim_busy1", 64'(busy[1]), 64'd1);
    chk("sim_err", 64'(err_underflow), 64'd0);

    // Underflow is sticky until reset
    do_reset();
    s_ack_valid = 1'b1;
    s_ack_id    = 2'd0;
    #1;
    tick();
    s_ack_valid = 1'b0;
    #1;
    chk("uf_err", 64'(err_underflow), 64'd1);
    chk("uf_out0", 64'(dut.outstanding[0]), 64'd0);
    repeat (3) tick();
    chk("uf_sticky", 64'(err_underflow), 64'd1);

    // Reset while FULL with five outstanding on requester 3
    do_reset();
    chk("uf_cleared", 64'(err_underflow), 64'd0);
    s_sq_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("r3_ready%0d", c), 64'(s_sq_ready), 64'h8);
      tick();
    end
    s_sq_valid = '0;
    m_sq_ready = 1'b0;
    #1;
    tick();
    chk("mid_full", 64'(m_sq_valid), 64'd1);
    chk("mid_out3", 64'(dut.outstanding[3]), 64'd5);
    chk("mid_busy", 64'(busy), 64'h8);
    #2;
    nreset     = 1'b1;
    s_sq_valid = 4'hF;
    m_sq_ready = 1'b1;
    #1;
    chk("arst_mvalid", 64'(m_sq_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_ready", 64'(s_sq_ready), 64'h0);
    @(posedge nclk);
    #1;
    nreset = 1'b0;
    #1;
    chk("post_ready", 64'(s_sq_ready), 64'h1);
    tick();
    chk("post_mvalid", 64'(m_sq_valid), 64'd1);
    chk("post_mid", 64'(m_sq_id), 64'd0);
    chk("post_out3", 64'(dut.outstanding[3]), 64'd0);

    // Credit limit of two on the second instance
    do_reset();
    l_valid = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("lim_ready%0d", c), 64'(l_ready), (c < 2) ? 64'h4 : 64'h0);
      tick();
    end
    l_ack_valid = 1'b1;
    l_ack_id    = 2'd2;
    #1;
    chk("lim_ack_cycle", 64'(l_ready), 64'h0);
    tick();
    l_ack_valid = 1'b0;
    #1;
    chk("lim_regrant", 64'(l_ready), 64'h4);
    tick();
    chk("lim_again", 64'(l_ready), 64'h0);
    chk("lim_mvalid", 64'(l_mvalid), 64'd1);
    chk("lim_mid", 64'(l_mid), 64'd2);
    chk("lim_err", 64'(l_err), 64'd0);

    // Randomized traffic against a reference model
    do_reset();
    for (int i = 0; i < N; i++) begin
      mout[i] = 0;
      mgr[i]  = 0;
    end
    mlast = N - 1; mv = 0; merr = 0; md = '0; mi = 0; mstall = 0;
    for (int c = 0; c < 3000; c++) begin
      s_sq_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        s_sq_data[i*RB +: RB] = {$urandom, $urandom};
      m_sq_ready  = ($urandom_range(0, 3) != 0);
      s_ack_valid = ($urandom_range(0, 2) == 0);
      aid = $urandom_range(0, N - 1);
      sel = -1;
      if ($urandom_range(0, 15) != 0)
        for (int k = 0; k < N; k++)
          if (sel < 0 && mout[(aid + k) % N] > 0) sel = (aid + k) % N;
      if (sel >= 0) aid = sel;
      s_ack_id = 2'(aid);
      #1;
      win = -1;
      if (!mv || m_sq_ready)
        for (int k = 1; k <= N; k++) begin
          j = (mlast + k) % N;
          if (win < 0 && s_sq_valid[j] && mout[j] < MO) win = j;
        end
      exp_rdy  = (win < 0) ? 4'h0 : (4'h1 << win);
      exp_busy = '0;
      for (int i = 0; i < N; i++) exp_busy[i] = (mout[i] != 0);
      chk("rnd_ready", 64'(s_sq_ready), 64'(exp_rdy));
      chk("rnd_mvalid", 64'(m_sq_valid), 64'(mv));
      if (mv) begin
        chk("rnd_mid", 64'(m_sq_id), 64'(mi));
        chk("rnd_mdata", m_sq_data, md);
      end
      chk("rnd_busy", 64'(busy), 64'(exp_busy));
      chk("rnd_err", 64'(err_underflow), 64'(merr));
      if (mv && !m_sq_ready) mstall++;
      if (mv && m_sq_ready) mv = 0;
      if (win >= 0) begin
        mv = 1;
        md = s_sq_data[win*RB +: RB];
        mi = win;
        mlast = win;
        mgr[win]++;
      end
      if (s_ack_valid && aid != win) begin
        if (mout[aid] == 0) merr = 1;
        else mout[aid]--;
      end
      if (win >= 0 && !(s_ack_valid && aid == win)) mout[win]++;
      tick();
    end
`ifdef RDMA_SQ_ARB_STATS_EN
    chk("rnd_stall", 64'(stat_stall), 64'(mstall));
    for (int i = 0; i < N; i++)
      chk($sformatf("rnd_grants%0d", i), 64'(stat_grants[i*32 +: 32]), 64'(mgr[i]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
